// File: rtl/priority_scan_encoder.sv
// priority_scan_encoder: accepts a word and emits the indices of its set bits,
// one per output handshake, in LSB-first or MSB-first priority order.
module priority_scan_encoder #(
   parameter int WIDTH = 8,
   parameter int LSB_FIRST = 1,
   localparam int POS_W = (WIDTH > 2) ? $clog2(WIDTH) : 1,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [POS_W-1:0] out_pos,
   output logic             out_last,
   output logic [CNT_W-1:0] out_count,
   output logic             zero_flag
);
   typedef enum logic {IDLE, SCAN} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] mask;
   logic [CNT_W-1:0] count, pop;
   logic [POS_W-1:0] pos;
   logic zero, single, in_xfer, out_xfer;
   assign in_xfer = in_valid & in_ready & ~abort;
   assign out_xfer = out_valid & out_ready;
   assign single = (mask != '0) && ((mask & (mask - WIDTH'(1))) == '0);
   assign out_count = count;
   assign zero_flag = zero;
   // Later loop iterations win, so scan from the low-priority end.
   always_comb begin
      pos = '0;
      for (int i = 0; i < WIDTH; i++)
         if (mask[(LSB_FIRST != 0) ? WIDTH-1-i : i]) pos = POS_W'((LSB_FIRST != 0) ? WIDTH-1-i : i);
   end
   always_comb begin
      pop = '0;
      for (int i = 0; i < WIDTH; i++) pop = pop + CNT_W'(in_data[i]);
   end
   always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nxt;
   always_comb
      state_nxt = abort ? IDLE
                : (state == IDLE) ? ((in_xfer && in_data != '0) ? SCAN : IDLE)
                : ((out_xfer && out_last) ? IDLE : SCAN);
   always_comb begin
      in_ready = state == IDLE;
      out_valid = state == SCAN;
      out_last = out_valid & single;
      out_pos = out_valid ? pos : '0;
   end
   always_ff @(posedge clk)
      if (!rst_n) begin
         mask <= '0;
         count <= '0;
         zero <= 1'b0;
      end else begin
         zero <= in_xfer && in_data == '0;
         if (abort) mask <= '0;
         else if (in_xfer) begin
            mask <= in_data;
            count <= pop;
         end else if (out_xfer) mask <= out_last ? '0 : mask & ~(WIDTH'(1) << pos);
      end
endmodule

// File: tb/tb_priority_scan_encoder.sv
// tb_priority_scan_encoder: checks three priority_scan_encoder configurations against a set-bit queue model
module tb_priority_scan_encoder;
  logic clk = 1'b0, rst_n = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic a_ir, a_ov, a_ol, a_zf, b_ir, b_ov, b_ol, b_zf, c_ir, c_ov, c_ol, c_zf;
  logic [2:0] a_pos, b_pos;
  logic [4:0] c_pos;
  logic [3:0] a_cnt, b_cnt;
  logic [5:0] c_cnt;
  int sel_r = 0, checks = 0, failures = 0;
  logic o_ready, o_valid, o_last, o_zero;
  int o_pos, o_count;
  always #5 clk = ~clk;
  priority_scan_encoder #(.WIDTH(8), .LSB_FIRST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(a_ir),
    .in_data(in_data[7:0]), .out_valid(a_ov), .out_ready(out_ready), .out_pos(a_pos),
    .out_last(a_ol), .out_count(a_cnt), .zero_flag(a_zf));
  priority_scan_encoder #(.WIDTH(8), .LSB_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(b_ir),
    .in_data(in_data[7:0]), .out_valid(b_ov), .out_ready(out_ready), .out_pos(b_pos),
    .out_last(b_ol), .out_count(b_cnt), .zero_flag(b_zf));
  priority_scan_encoder #(.WIDTH(32), .LSB_FIRST(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(c_ir),
    .in_data(in_data), .out_valid(c_ov), .out_ready(out_ready), .out_pos(c_pos),
    .out_last(c_ol), .out_count(c_cnt), .zero_flag(c_zf));
  always_comb begin
    o_ready = sel_r == 0 ? a_ir : sel_r == 1 ? b_ir : c_ir;
    o_valid = sel_r == 0 ? a_ov : sel_r == 1 ? b_ov : c_ov;
    o_last = sel_r == 0 ? a_ol : sel_r == 1 ? b_ol : c_ol;
    o_zero = sel_r == 0 ? a_zf : sel_r == 1 ? b_zf : c_zf;
    o_pos = sel_r == 0 ? int'(a_pos) : sel_r == 1 ? int'(b_pos) : int'(c_pos);
    o_count = sel_r == 0 ? int'(a_cnt) : sel_r == 1 ? int'(b_cnt) : int'(c_cnt);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    sel_r = 0;
    rst_n = 1'b0;
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      sel_r = s;
      #0;
      checks++;
      if (o_valid !== 1'b0 || o_last !== 1'b0 || o_pos !== 0 || o_count !== 0 || o_zero !== 1'b0) begin
        failures++;
        $display("FAIL reset sel=%0d got v=%b l=%b p=%0d c=%0d z=%b want all zero", s, o_valid, o_last, o_pos, o_count, o_zero);
      end
    end
    sel_r = 0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got %b want 1", o_ready);
    end
  endtask
  task automatic test_scan(input int sel, input logic [31:0] w, input int mode);
    int q[$];
    int n, bits, cyc;
    sel_r = sel;
    bits = sel == 2 ? 32 : 8;
    for (int i = 0; i < bits; i++) begin
      int idx;
      idx = sel == 1 ? bits - 1 - i : i;
      if (w[idx]) q.push_back(idx);
    end
    n = q.size();
    #0;
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL scan_in_ready sel=%0d got %b want 1", sel, o_ready);
    end
    in_valid = 1'b1;
    in_data = w;
    tick();
    in_valid = 1'b0;
    checks++;
    if (o_count !== n) begin
      failures++;
      $display("FAIL scan_count sel=%0d w=%h got %0d want %0d", sel, w, o_count, n);
    end
    if (n == 0) begin
      checks++;
      if (o_zero !== 1'b1 || o_valid !== 1'b0) begin
        failures++;
        $display("FAIL zero_word sel=%0d got z=%b v=%b want z=1 v=0", sel, o_zero, o_valid);
      end
    end
    cyc = 0;
    while (q.size() > 0 && cyc < 400) begin
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : 1'(cyc >= 3);
      checks++;
      if (o_valid !== 1'b1 || o_pos !== q[0] || o_last !== 1'(q.size() == 1)) begin
        failures++;
        $display("FAIL scan_emit sel=%0d w=%h got v=%b p=%0d l=%b want v=1 p=%0d l=%b",
                 sel, w, o_valid, o_pos, o_last, q[0], q.size() == 1);
      end
      tick();
      if (out_ready) void'(q.pop_front());
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scan_timeout sel=%0d w=%h left %0d want 0", sel, w, q.size());
    end
    if (mode == 0) begin
      checks++;
      if (cyc != n) begin
        failures++;
        $display("FAIL scan_rate sel=%0d got %0d cycles want %0d", sel, cyc, n);
      end
    end
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_last !== 1'b0 || o_pos !== 0 || (n > 0 && o_zero !== 1'b0)) begin
      failures++;
      $display("FAIL scan_end sel=%0d got v=%b r=%b l=%b p=%0d z=%b want 0 1 0 0 0", sel, o_valid, o_ready, o_last, o_pos, o_zero);
    end
  endtask
  task automatic test_directed;
    test_scan(0, 32'h94, 0);
    test_scan(0, 32'h94, 2);
    test_scan(0, 32'h00, 0);
    test_scan(1, 32'h81, 0);
    test_scan(0, 32'h81, 0);
    test_scan(2, 32'h8000_0001, 0);
  endtask
  task automatic test_abort;
    sel_r = 0;
    in_valid = 1'b1;
    in_data = 32'hFF;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_pos !== 1) begin
      failures++;
      $display("FAIL abort_pre got v=%b p=%0d want v=1 p=1", o_valid, o_pos);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_count !== 8) begin
      failures++;
      $display("FAIL abort_idle got v=%b r=%b c=%0d want v=0 r=1 c=8", o_valid, o_ready, o_count);
    end
    in_valid = 1'b1;
    in_data = 32'h55;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_zero !== 1'b0 || o_count !== 8) begin
      failures++;
      $display("FAIL abort_capture got v=%b z=%b c=%0d want v=0 z=0 c=8", o_valid, o_zero, o_count);
    end
    test_scan(0, 32'h10, 0);
  endtask
  task automatic test_reset_mid_scan;
    sel_r = 0;
    in_valid = 1'b1;
    in_data = 32'hF0;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_last !== 1'b0 || o_pos !== 0 || o_count !== 0 || o_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got v=%b l=%b p=%0d c=%0d z=%b want all zero", o_valid, o_last, o_pos, o_count, o_zero);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_after got v=%b r=%b want v=0 r=1", o_valid, o_ready);
    end
    out_ready = 1'b0;
  endtask
  task automatic test_back_to_back;
    test_scan(0, 32'h03, 0);
    test_scan(0, 32'hC0, 0);
    test_scan(2, 32'h0001_0100, 1);
  endtask
  task automatic test_random;
    for (int k = 0; k < 30; k++) begin
      int s;
      logic [31:0] w;
      s = $urandom_range(0, 2);
      w = $urandom;
      if (s != 2) w = w & 32'hFF;
      if ($urandom_range(0, 7) == 0) w = '0;
      test_scan(s, w, 1);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_reset_mid_scan();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/priority_scan_encoder.md
PRIORITY_SCAN_ENCODER -- requirements
Module: priority_scan_encoder

Interface
REQ-001 Parameter WIDTH, default 8: input word width; legal range 2..256.
REQ-002 Parameter LSB_FIRST, default 1: 1 = lowest set bit has priority; 0 = highest set bit has priority.
REQ-003 Derived POS_W = max(1, clog2(WIDTH)); CNT_W = clog2(WIDTH+1).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 abort  input  1  synchronous scan cancel.
REQ-007 in_valid  input  1  in_data offered.
REQ-008 in_ready  output  1  block can accept a word.
REQ-009 in_data  input  WIDTH  word to be scanned.
REQ-010 out_valid  output  1  out_pos holds a valid index.
REQ-011 out_ready  input  1  consumer accepts out_pos.
REQ-012 out_pos  output  POS_W  index of current highest-priority remaining set bit.
REQ-013 out_last  output  1  current out_pos is the final set bit of the word.
REQ-014 out_count  output  CNT_W  popcount of the word being scanned.
REQ-015 zero_flag  output  1  one-cycle pulse: an all-zero word was accepted.

Function
REQ-016 States: IDLE, SCAN; mask register (WIDTH bits) holds not-yet-emitted set bits.
REQ-017 in_ready SHALL equal 1 in IDLE and 0 in SCAN; input transfer = in_valid & in_ready.
REQ-018 Transfer with nonzero in_data: mask <= in_data, out_count <= popcount(in_data), state -> SCAN; out_valid high from the next cycle (1-cycle latency).
REQ-019 Transfer with in_data == 0: state stays IDLE, zero_flag = 1 for exactly the next cycle, out_count <= 0, out_valid stays 0.
REQ-020 In SCAN, out_valid = 1; out_pos = index of lowest (LSB_FIRST=1) or highest (LSB_FIRST=0) set bit of mask, derived combinationally from the mask register.
REQ-021 out_last = 1 iff exactly one bit of mask is set while in SCAN; otherwise 0.
REQ-022 Output transfer (out_valid & out_ready): clear mask[out_pos]; if out_last, state -> IDLE and mask -> 0.
REQ-023 While out_ready = 0, out_pos, out_last and mask SHALL hold stable.
REQ-024 Exactly popcount(in_data) output transfers per word, no index repeated or skipped; with out_ready held 1 one index per cycle.
REQ-025 In IDLE, out_valid = 0, out_last = 0, out_pos = 0.
REQ-026 out_count SHALL hold its value until the next input transfer.
REQ-027 abort = 1 (rst_n = 1): next cycle state = IDLE, mask = 0, out_valid = 0; out_count holds; no input transfer that cycle (in_ready may read 1 in IDLE but capture is suppressed).
REQ-028 Priority: rst_n low > abort > input/output transfer.
REQ-029 Back-to-back: a new word may be accepted the cycle after out_last transfer (no extra idle cycle required beyond IDLE state).

Reset
REQ-030 rst_n = 0 at a rising edge: state = IDLE, mask = 0, out_count = 0, zero_flag = 0, out_valid = 0, out_last = 0, out_pos = 0; in_ready = 1 after release.
REQ-031 Reset asserted mid-scan SHALL discard the word without emitting remaining indices.

Verification (WIDTH=8 unless stated)
REQ-032 in_data=8'b1001_0100, out_ready=1, LSB_FIRST=1 -> out_pos 2,4,7 on three consecutive cycles, out_last only with 7, out_count=3, in_ready=1 the following cycle.
REQ-033 Same word, out_ready=0 for 3 cycles after out_valid rises -> out_pos held at 2 with out_valid=1; then 2,4,7 emitted once each.
REQ-034 in_data=8'h00 -> zero_flag=1 for one cycle, out_valid never 1, in_ready stays 1.
REQ-035 LSB_FIRST=0, in_data=8'h81 -> out_pos 7 then 0, out_last with 0; LSB_FIRST=1 -> 0 then 7.
REQ-036 in_data=8'hFF, abort after first transfer -> out_valid=0 next cycle, state IDLE, new word 8'h10 then yields single out_pos 4 with out_last=1.
REQ-037 rst_n=0 mid-scan of 8'hF0 -> all outputs at reset values next cycle; WIDTH=32 run with 32'h8000_0001 yields 0 then 31.
